// File: rtl/axil_vga_reg_bank.sv
// axil_vga_reg_bank: AXI4-Lite register bank with per-register RW / RO-status / W1C-event modes.
module axil_vga_reg_bank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0,
    parameter logic [NUM_REGS-1:0] W1C_MASK = '0
) (
    input  logic                             ACLK,
    input  logic                             ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]    S_AXI_AWADDR,
    input  logic [2:0]                       S_AXI_AWPROT,
    input  logic                             S_AXI_AWVALID,
    output logic                             S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]    S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]  S_AXI_WSTRB,
    input  logic                             S_AXI_WVALID,
    output logic                             S_AXI_WREADY,
    output logic [1:0]                       S_AXI_BRESP,
    output logic                             S_AXI_BVALID,
    input  logic                             S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]    S_AXI_ARADDR,
    input  logic [2:0]                       S_AXI_ARPROT,
    input  logic                             S_AXI_ARVALID,
    output logic                             S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]    S_AXI_RDATA,
    output logic [1:0]                       S_AXI_RRESP,
    output logic                             S_AXI_RVALID,
    input  logic                             S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] event_set,
    output logic [NUM_REGS-1:0]              wr_pulse
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int LSB = $clog2(SW);
    localparam int IW = C_S_AXI_ADDR_WIDTH - LSB;
    logic ready_en, aw_q, w_q, commit, rd_ok, unused;
    logic [IW-1:0] aw_idx, ar_idx;
    logic [DW-1:0] w_data, bmask, rd_val;
    logic [SW-1:0] w_strb;
    logic [DW-1:0] view [NUM_REGS];
    logic [NUM_REGS-1:0] wr_hit;
    assign S_AXI_AWREADY = ready_en && !aw_q && !S_AXI_BVALID;
    assign S_AXI_WREADY = ready_en && !w_q && !S_AXI_BVALID;
    assign S_AXI_ARREADY = ready_en && !S_AXI_RVALID;
    assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
    assign commit = aw_q && w_q;
    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0],
                      status_in, event_set};
    always_comb begin
        bmask = '0;
        for (int b = 0; b < SW; b++) bmask[b*8 +: 8] = {8{w_strb[b]}};
    end
    always_comb begin
        rd_val = '0;
        rd_ok = 1'b0;
        for (int j = 0; j < NUM_REGS; j++)
            if (ar_idx == IW'(j)) begin
                rd_val = view[j];
                rd_ok = 1'b1;
            end
    end
    genvar i;
    generate
        for (i = 0; i < NUM_REGS; i++) begin : g_reg
            logic [DW-1:0] r;
            assign wr_hit[i] = commit && aw_idx == IW'(i) && !RO_MASK[i];
            assign view[i] = RO_MASK[i] ? status_in[i*DW +: DW] : r;
            assign reg_out[i*DW +: DW] = view[i];
            // Hardware set is OR-ed after the clear so a same-cycle set wins.
            always_ff @(posedge ACLK) begin
                if (!ARESETN || RO_MASK[i])
                    r <= '0;
                else if (W1C_MASK[i])
                    r <= (r & ~(wr_hit[i] ? (w_data & bmask) : '0)) | event_set[i*DW +: DW];
                else if (wr_hit[i])
                    r <= (r & ~bmask) | (w_data & bmask);
            end
        end
    endgenerate
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            ready_en <= 1'b0;
            aw_q <= 1'b0;
            w_q <= 1'b0;
            aw_idx <= '0;
            w_data <= '0;
            w_strb <= '0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP <= 2'b00;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= 2'b00;
            wr_pulse <= '0;
        end else begin
            ready_en <= 1'b1;
            wr_pulse <= wr_hit;
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                aw_q <= 1'b1;
                aw_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                w_q <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            if (commit) begin
                aw_q <= 1'b0;
                w_q <= 1'b0;
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP <= |wr_hit ? 2'b00 : 2'b10;
            end else if (S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA <= rd_val;
                S_AXI_RRESP <= rd_ok ? 2'b00 : 2'b10;
            end else if (S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end
endmodule
